mvm_seq_ctrl: RTL

//  Control FSM for the streaming y = M*x + b matrix-vector engine.
//  - Accepts one SIZE*SIZE+2*SIZE element job over a valid/ready input stream.
//  - Generates write enables and addresses for the M, x and b memories, then

---
 rtl/mvm_seq_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/mvm_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mvm_seq_ctrl
//   Control FSM for the streaming y = M*x + b matrix-vector engine.
//   One job is SIZE*SIZE M elements, then SIZE x elements, then SIZE b elements
//   on a valid/ready input stream. After loading, each row runs a bias preload
//   followed by SIZE multiply-accumulates. The row result is then offered on a
//   valid/ready output stream. This block has no data ports; the datapath
//   consumes its strobes and addresses.
//
//   Optional feature: define MVM_CYCLE_CNT_EN to add the cycle_cnt output
//   (job duration from first M transfer to final output handshake).
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   s_valid    in   input element valid
//   s_ready    out  controller accepts an input element (LOAD_* states only)
//   m_valid    out  y[row] valid on datapath output
//   m_ready    in   consumer accepts y[row]
//   wr_m/x/b   out  write current input element to M / x / b memory
//   addr_m     out  M read/write address (row-major)
//   addr_x     out  x read/write address
//   addr_b     out  b read/write address
//   load_bias  out  accumulator <= b[addr_b of previous cycle]
//   en_acc     out  accumulator += M*x read out in the previous cycle
//   cycle_cnt  out  [MVM_CYCLE_CNT_EN only] saturating job cycle count
// -----------------------------------------------------------------------------
module mvm_seq_ctrl #(
   parameter int SIZE = 3,
   parameter int AW_M = $clog2(SIZE*SIZE),
   parameter int AW_V = $clog2(SIZE)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            s_valid,
   output logic            s_ready,
   output logic            m_valid,
   input  logic            m_ready,
   output logic            wr_m,
   output logic            wr_x,
   output logic            wr_b,
   output logic [AW_M-1:0] addr_m,
   output logic [AW_V-1:0] addr_x,
   output logic [AW_V-1:0] addr_b,
   output logic            load_bias,
   output logic            en_acc
`ifdef MVM_CYCLE_CNT_EN
   ,
   output logic [31:0]     cycle_cnt
`endif
);

   typedef enum logic [2:0] {
      LOAD_M, LOAD_X, LOAD_B, CLR, MAC, DRAIN, OUT
   } state_t;

   localparam logic [AW_M-1:0] M_LAST = AW_M'(SIZE*SIZE - 1);
   localparam logic [AW_V-1:0] V_LAST = AW_V'(SIZE - 1);

   state_t          state;
   logic [AW_V-1:0] row;
   logic            xfer;
   logic            out_hs;

   // s_ready is a register that is only set in LOAD_*, so gating with it keeps
   // the write strobes low during reset and outside the load phase.
   assign xfer   = s_valid && s_ready;
   assign wr_m   = xfer && (state == LOAD_M);
   assign wr_x   = xfer && (state == LOAD_X);
   assign wr_b   = xfer && (state == LOAD_B);
   assign out_hs = m_valid && m_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= LOAD_M;
         row       <= '0;
         s_ready   <= 1'b0;
         m_valid   <= 1'b0;
         addr_m    <= '0;
         addr_x    <= '0;
         addr_b    <= '0;
         load_bias <= 1'b0;
         en_acc    <= 1'b0;
      end else begin
         // Memory reads take one cycle, so the accumulator strobes trail the
         // cycle that presented the read address.
         load_bias <= (state == CLR);
         en_acc    <= (state == MAC);
         case (state)
            LOAD_M: begin
               s_ready <= 1'b1;
               if (xfer) begin
                  if (addr_m == M_LAST) begin
                     addr_m <= '0;
                     state  <= LOAD_X;
                  end else begin
                     addr_m <= addr_m + AW_M'(1);
                  end
               end
            end
            LOAD_X: begin
               s_ready <= 1'b1;
               if (xfer) begin
                  if (addr_x == V_LAST) begin
                     addr_x <= '0;
                     state  <= LOAD_B;
                  end else begin
                     addr_x <= addr_x + AW_V'(1);
                  end
               end
            end
            LOAD_B: begin
               s_ready <= 1'b1;
               if (xfer) begin
                  if (addr_b == V_LAST) begin
                     // addr_b = row = 0 during the first CLR cycle
                     addr_b  <= '0;
                     row     <= '0;
                     s_ready <= 1'b0;
                     state   <= CLR;
                  end else begin
                     addr_b <= addr_b + AW_V'(1);
                  end
               end
            end
            CLR: begin
               addr_m <= AW_M'(int'(row) * SIZE);
               addr_x <= '0;
               state  <= MAC;
            end
            MAC: begin
               // Addresses stop on the last k and stay frozen through DRAIN/OUT.
               if (addr_x == V_LAST) begin
                  state <= DRAIN;
               end else begin
                  addr_m <= addr_m + AW_M'(1);
                  addr_x <= addr_x + AW_V'(1);
               end
            end
            DRAIN: begin
               m_valid <= 1'b1;
               state   <= OUT;
            end
            OUT: begin
               if (out_hs) begin
                  m_valid <= 1'b0;
                  if (row == V_LAST) begin
                     s_ready <= 1'b1;
                     row     <= '0;
                     addr_m  <= '0;
                     addr_x  <= '0;
                     addr_b  <= '0;
                     state   <= LOAD_M;
                  end else begin
                     row    <= row + AW_V'(1);
                     addr_b <= row + AW_V'(1);
                     state  <= CLR;
                  end
               end
            end
            default: state <= LOAD_M;
         endcase
      end
   end

`ifdef MVM_CYCLE_CNT_EN
   logic [31:0] run_cnt;
   logic        running;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // run_cnt holds the cycles already counted before the current one, so the
   // value latched at the final handshake includes that handshake cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         run_cnt   <= '0;
         running   <= 1'b0;
         cycle_cnt <= '0;
      end else if (wr_m && (addr_m == '0)) begin
         run_cnt <= 32'd1;
         running <= 1'b1;
      end else if (running) begin
         if (out_hs && (row == V_LAST)) begin
            cycle_cnt <= sat_inc(run_cnt);
            running   <= 1'b0;
         end else begin
            run_cnt <= sat_inc(run_cnt);
         end
      end
   end
`endif

endmodule
